noise_burst_ctrl: RTL and testbench

- Sequences and gates the 16-line resistor-DAC noise word from the LFSR noise generator before it reaches the output pins.
- Provides soft amplitude ramping, so that no step appears on the AC-coupled output. Amplitude is set by the number of active DAC lines.
- Supports continuous or burst (on/off keyed) operation.
- Sits between the noise combiner and the DAC pins, and is configured through a small register-write port.

---
 rtl/noise_burst_ctrl.sv | 133 +++++++++++++
 tb/tb_noise_burst_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noise_burst_ctrl.sv
// Gates and amplitude-ramps the 16-line resistor-DAC noise word.
// Supports continuous or burst (on/off keyed) operation via a small config port.
module noise_burst_ctrl #(
  parameter logic [15:0] IDLE_PAT     = 16'hAAAA,
  parameter int unsigned RST_LEVEL    = 16,
  parameter int unsigned RST_RAMP_DIV = 49,
  parameter int unsigned CW           = 16
) (
  input  logic        sclk,
  input  logic        srst,
  input  logic        en,
  input  logic [15:0] noise_in,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  output logic [15:0] dac,
  output logic [4:0]  level,
  output logic [2:0]  state,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_ON        = 3'd2,
    S_RAMP_DOWN = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  state_t        st, nxt_st;
  logic [4:0]    cur_lvl, nxt_lvl, tgt_lvl, wr_lvl;
  logic          burst_en;
  logic [CW-1:0] ramp_div, on_len, off_len, on_eff, off_eff;
  logic [CW-1:0] rcnt, ocnt;
  logic          ramping, tick;
  logic [16:0]   mask_w;

  assign on_eff  = (on_len  == '0) ? CW'(1) : on_len;
  assign off_eff = (off_len == '0) ? CW'(1) : off_len;
  assign ramping = (st == S_RAMP_UP) || (st == S_ON) || (st == S_RAMP_DOWN);
  // >= keeps the divider sane if ramp_div is lowered below the running count
  assign tick    = ramping && (rcnt >= ramp_div);
  assign mask_w  = (17'd1 << cur_lvl) - 17'd1;
  assign wr_lvl  = (cfg_wdata[4:0] > 5'd16) ? 5'd16 : cfg_wdata[4:0];

  always_comb begin
    nxt_st  = st;
    nxt_lvl = cur_lvl;
    unique case (st)
      S_IDLE: begin
        nxt_lvl = '0;
        if (en && tgt_lvl != '0) nxt_st = S_RAMP_UP;
      end
      S_RAMP_UP: begin
        if (!en) begin
          nxt_st = S_RAMP_DOWN;
        end else if (tgt_lvl <= cur_lvl) begin
          nxt_st = S_ON;
        end else if (tick) begin
          nxt_lvl = cur_lvl + 5'd1;
          if (cur_lvl + 5'd1 == tgt_lvl) nxt_st = S_ON;
        end
      end
      S_ON: begin
        if (!en || (burst_en && ocnt >= on_eff - CW'(1))) begin
          nxt_st = S_RAMP_DOWN;
        end else if (tick) begin
          if (cur_lvl < tgt_lvl)      nxt_lvl = cur_lvl + 5'd1;
          else if (cur_lvl > tgt_lvl) nxt_lvl = cur_lvl - 5'd1;
        end
      end
      S_RAMP_DOWN: begin
        if (tick && cur_lvl != '0) nxt_lvl = cur_lvl - 5'd1;
        if (cur_lvl == '0 || (tick && cur_lvl == 5'd1))
          nxt_st = (en && burst_en) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        nxt_lvl = '0;
        if (!en)                             nxt_st = S_IDLE;
        else if (ocnt >= off_eff - CW'(1))   nxt_st = S_RAMP_UP;
      end
      default: begin
        nxt_st  = S_IDLE;
        nxt_lvl = '0;
      end
    endcase
  end

  always_ff @(posedge sclk) begin
    if (srst) begin
      st       <= S_IDLE;
      cur_lvl  <= '0;
      busy     <= 1'b0;
      dac      <= IDLE_PAT;
      rcnt     <= '0;
      ocnt     <= '0;
      tgt_lvl  <= 5'(RST_LEVEL);
      burst_en <= 1'b0;
      ramp_div <= CW'(RST_RAMP_DIV);
      on_len   <= CW'(1000);
      off_len  <= CW'(1000);
    end else begin
      st      <= nxt_st;
      cur_lvl <= nxt_lvl;
      busy    <= (nxt_st != S_IDLE);
      dac     <= (noise_in & mask_w[15:0]) | (IDLE_PAT & ~mask_w[15:0]);

      if (nxt_st != st || !ramping || tick) rcnt <= '0;
      else                                  rcnt <= rcnt + CW'(1);

      // saturating so a late burst_en enable in a long ON dwell ends the burst at once
      if (nxt_st != st || !(st == S_ON || st == S_GAP)) ocnt <= '0;
      else if (ocnt != '1)                               ocnt <= ocnt + CW'(1);

      if (cfg_we) begin
        unique case (cfg_addr)
          2'd0: begin
            tgt_lvl  <= wr_lvl;
            burst_en <= cfg_wdata[8];
          end
          2'd1: ramp_div <= CW'(cfg_wdata);
          2'd2: on_len   <= CW'(cfg_wdata);
          2'd3: off_len  <= CW'(cfg_wdata);
          default: ;
        endcase
      end
    end
  end

  assign level = cur_lvl;
  assign state = st;

endmodule

// File: tb/tb_noise_burst_ctrl.sv
// Bench for noise_burst_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_noise_burst_ctrl;

  logic        sclk = 1'b0;
  logic        srst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] noise_in = 16'hFFFF;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [15:0] cfg_wdata = 16'h0000;
  logic [15:0] dac;
  logic [4:0]  level;
  logic [2:0]  state;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  always #5 sclk = ~sclk;

  noise_burst_ctrl #(
    .IDLE_PAT(16'hAAAA), .RST_LEVEL(16), .RST_RAMP_DIV(49), .CW(16)
  ) dut (
    .sclk(sclk), .srst(srst), .en(en), .noise_in(noise_in),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .dac(dac), .level(level), .state(state), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state numbers as the output encoding, levels as plain ints.
  int          m_st, m_lvl, m_tgt, m_div, m_on, m_off, m_since, m_dwell;
  bit          m_burst;
  logic [15:0] m_dac;

  function automatic logic [15:0] mix(input logic [15:0] n, input int lv);
    int unsigned mm;
    logic [15:0] m;
    mm = (32'd1 << lv) - 32'd1;
    m  = mm[15:0];
    return (n & m) | (16'hAAAA & ~m);
  endfunction

  task automatic model_step();
    int  nst, nl, onl, offl;
    bit  tk, leave_to_gap;
    if (srst) begin
      m_st = 0; m_lvl = 0; m_tgt = 16; m_div = 49; m_on = 1000; m_off = 1000;
      m_since = 0; m_dwell = 0; m_burst = 1'b0; m_dac = 16'hAAAA;
      return;
    end
    m_dac = mix(noise_in, m_lvl);
    onl  = (m_on  == 0) ? 1 : m_on;
    offl = (m_off == 0) ? 1 : m_off;
    tk   = (m_st >= 1 && m_st <= 3) && (m_since >= m_div);
    leave_to_gap = en && m_burst;
    nst = m_st;
    nl  = m_lvl;
    case (m_st)
      0: begin nl = 0; if (en && m_tgt != 0) nst = 1; end
      1: begin
        if (!en) nst = 3;
        else if (m_tgt <= m_lvl) nst = 2;
        else if (tk) begin nl = m_lvl + 1; if (nl == m_tgt) nst = 2; end
      end
      2: begin
        if (!en || (m_burst && m_dwell + 1 >= onl)) nst = 3;
        else if (tk) nl = m_lvl + ((m_tgt > m_lvl) ? 1 : (m_tgt < m_lvl) ? -1 : 0);
      end
      3: begin
        if (m_lvl == 0) nst = leave_to_gap ? 4 : 0;
        else if (tk) begin nl = m_lvl - 1; if (nl == 0) nst = leave_to_gap ? 4 : 0; end
      end
      default: begin
        nl = 0;
        if (!en) nst = 0;
        else if (m_dwell + 1 >= offl) nst = 1;
      end
    endcase
    if (nst != m_st) begin m_since = 0; m_dwell = 0; end
    else begin m_since = tk ? 0 : m_since + 1; m_dwell++; end
    m_st  = nst;
    m_lvl = nl;
    if (cfg_we) begin
      case (cfg_addr)
        2'd0: begin m_tgt = (cfg_wdata[4:0] > 5'd16) ? 16 : int'(cfg_wdata[4:0]); m_burst = cfg_wdata[8]; end
        2'd1: m_div = int'(cfg_wdata);
        2'd2: m_on  = int'(cfg_wdata);
        default: m_off = int'(cfg_wdata);
      endcase
    end
  endtask

  initial forever begin
    @(posedge sclk);
    model_step();
  end

  initial forever begin
    @(negedge sclk);
    if (chk_on) begin
      chk("cyc_dac",   dac,   m_dac);
      chk("cyc_level", level, m_lvl);
      chk("cyc_state", state, m_st);
      chk("cyc_busy",  busy,  m_st != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge sclk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic wait_state(input string name, input int st_want, input int limit);
    int n = 0;
    while (state != st_want && n < limit) begin cyc(); n++; end
    chk(name, state, st_want);
  endtask

  logic [15:0] dac_lit [0:3];
  logic [2:0]  s [0:79];

  initial begin
    int n, mx, a1, a2, bad, exp_s;
    dac_lit[0] = 16'hAAAA; dac_lit[1] = 16'hAAAB; dac_lit[2] = 16'hAAAB; dac_lit[3] = 16'hAAAF;

    // reset
    cyc(); cyc();
    chk("rst_dac", dac, 16'hAAAA);
    chk("rst_level", level, 0);
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk_on = 1'b1;
    srst = 1'b0;

    // ramp up, one step per cycle
    wr(2'd1, 16'd0);
    wr(2'd0, 16'd16);
    en = 1'b1;
    cyc();
    chk("ru_state0", state, 1);
    chk("ru_level0", level, 0);
    for (int i = 1; i <= 16; i++) begin
      cyc();
      chk("ru_level", level, i);
      chk("ru_state", state, (i < 16) ? 1 : 2);
      if (i <= 4) chk("ru_dac_lit", dac, dac_lit[i-1]);
    end
    cyc();
    chk("ru_dac_full", dac, 16'hFFFF);

    // ramp down on en drop, ramp_div=3
    wr(2'd1, 16'd3);
    en = 1'b0;
    cyc();
    chk("rd_state", state, 3);
    chk("rd_level", level, 16);
    n = 0;
    while (level != 0 && n < 200) begin cyc(); n++; end
    chk("rd_cycles", n, 64);
    chk("rd_idle", state, 0);
    cyc();
    chk("rd_dac", dac, 16'hAAAA);

    // burst keying
    wr(2'd1, 16'd0);
    wr(2'd2, 16'd10);
    wr(2'd3, 16'd5);
    wr(2'd0, 16'h0104);
    en = 1'b1;
    mx = 0;
    for (int k = 0; k < 80; k++) begin
      cyc();
      s[k] = state;
      if (int'(level) > mx) mx = int'(level);
    end
    a1 = -1; a2 = -1;
    for (int k = 1; k < 80; k++)
      if (s[k] == 3'd1 && s[k-1] == 3'd4) begin
        if (a1 < 0) a1 = k;
        else if (a2 < 0) a2 = k;
      end
    chk("burst_first_start", a1, 23);
    chk("burst_period", a2 - a1, 23);
    bad = 0;
    if (a1 > 0) begin
      for (int k = 0; k < 23; k++) begin
        exp_s = (k < 4) ? 1 : (k < 14) ? 2 : (k < 18) ? 3 : 4;
        if (s[a1 + k] != 3'(exp_s)) bad++;
      end
    end else bad = 99;
    chk("burst_seq_errs", bad, 0);
    chk("burst_max_level", mx, 4);
    en = 1'b0;
    wait_state("burst_idle", 0, 100);

    // live target change in ON
    wr(2'd0, 16'd16);
    en = 1'b1;
    n = 0;
    while (!(state == 3'd2 && level == 5'd16) && n < 100) begin cyc(); n++; end
    chk("lt_on16", level, 16);
    wr(2'd0, 16'd8);
    chk("lt_hold", level, 16);
    for (int i = 15; i >= 8; i--) begin
      cyc();
      chk("lt_level", level, i);
      chk("lt_state", state, 2);
    end
    cyc();
    chk("lt_settle", level, 8);
    wr(2'd0, 16'd20);
    for (int i = 0; i < 10; i++) cyc();
    chk("lt_sat_level", level, 16);
    chk("lt_sat_state", state, 2);

    // reset in the middle of a ramp
    en = 1'b0;
    wait_state("mr_idle", 0, 100);
    en = 1'b1;
    n = 0;
    while (level != 5'd7 && n < 100) begin cyc(); n++; end
    chk("mr_pre_state", state, 1);
    srst = 1'b1;
    cyc();
    chk("mr_level", level, 0);
    chk("mr_dac", dac, 16'hAAAA);
    chk("mr_state", state, 0);
    chk("mr_busy", busy, 0);
    srst = 1'b0;
    cyc();
    chk("mr_restart", state, 1);
    n = 0;
    while (level != 5'd1 && n < 200) begin cyc(); n++; end
    chk("mr_div49", n, 50);

    // randomized traffic, model compare every cycle
    for (int k = 0; k < 3000; k++) begin
      noise_in = 16'($urandom);
      if ($urandom_range(0, 49) == 0) en = ~en;
      srst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 19) == 0) begin
        cfg_we   = 1'b1;
        cfg_addr = 2'($urandom_range(0, 3));
        case (cfg_addr)
          2'd0:    cfg_wdata = 16'($urandom) & 16'h011F;
          2'd1:    cfg_wdata = 16'($urandom_range(0, 3));
          default: cfg_wdata = 16'($urandom_range(0, 12));
        endcase
      end else begin
        cfg_we = 1'b0;
      end
      cyc();
    end
    srst = 1'b0;
    cfg_we = 1'b0;
    cyc();
    cyc();
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
